// File: rtl/battle_engine.sv
// -----------------------------------------------------------------------------
// battle_engine
//   Turn-based battle sequencer. A rising edge of start_battle in IDLE starts a
//   battle against opponent cur_battle. The player picks one of four moves with
//   W/S and fires it with ENTER; the enemy strikes back after each player
//   attack. A member whose HP reaches 0 faints and the next team slot steps in.
//   The battle ends when the enemy or the last team member reaches 0 HP.
//
// Ports
//   Clk, Reset     : clock, synchronous active-high reset
//   start_battle   : level from roam logic, battle begins on its rising edge
//   keycode[7:0]   : current key code (0x00 = none, W=0x1A, S=0x16, ENTER=0x28)
//   my_team[8:0]   : three 3-bit creature ids (carried for display logic only)
//   cur_battle[2:0]: opponent index 0..4
//   end_battle     : one-cycle pulse when a battle finishes
//   result         : 1 = player won, 0 = player lost
//   my_cur[1:0]    : active team slot
//   enemy_cur_id   : opponent creature id
//   my_hp, enemy_hp: current HP values
//   menu_sel[1:0]  : highlighted move
//   phase[2:0]     : encoded state for display logic
// -----------------------------------------------------------------------------
module battle_engine #(
   parameter int unsigned WAIT_CYCLES = 25_000_000,
   parameter int unsigned MY_MAX_HP   = 100
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       start_battle,
   input  logic [7:0] keycode,
   input  logic [8:0] my_team,
   input  logic [2:0] cur_battle,
   output logic       end_battle,
   output logic       result,
   output logic [1:0] my_cur,
   output logic [2:0] enemy_cur_id,
   output logic [7:0] my_hp,
   output logic [7:0] enemy_hp,
   output logic [1:0] menu_sel,
   output logic [2:0] phase
);

   localparam logic [2:0] S_IDLE          = 3'd0;
   localparam logic [2:0] S_INIT          = 3'd1;
   localparam logic [2:0] S_PLAYER_TURN   = 3'd2;
   localparam logic [2:0] S_PLAYER_ATTACK = 3'd3;
   localparam logic [2:0] S_ENEMY_ATTACK  = 3'd4;
   localparam logic [2:0] S_FAINT         = 3'd5;
   localparam logic [2:0] S_DONE          = 3'd6;

   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_ENTER = 8'h28;

   localparam logic [7:0] MAX_HP = 8'(MY_MAX_HP);
   localparam int unsigned CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          result_q, result_d;
   logic [1:0]    my_cur_q, my_cur_d;
   logic [2:0]    enemy_id_q, enemy_id_d;
   logic [7:0]    my_hp_q, my_hp_d;
   logic [7:0]    enemy_hp_q, enemy_hp_d;
   logic [1:0]    menu_sel_q, menu_sel_d;
   logic [7:0]    prev_key_q, prev_key_d;
   logic          prev_start_q, prev_start_d;
   logic          start_armed_q, start_armed_d;

   logic       key_press;
   logic       start_edge;
   logic       wait_done;
   logic [7:0] player_dmg;
   logic [7:0] enemy_dmg;

   // my_team only feeds sprite selection outside this block
   logic unused_team;
   assign unused_team = ^my_team;

   assign key_press  = (keycode != 8'h00) && (keycode != prev_key_q);
   // start_armed_q stays low after reset until start_battle has been seen low,
   // so a level already high at reset release cannot start a battle
   assign start_edge = start_battle && !prev_start_q && start_armed_q;
   assign wait_done  = (cnt_q == CNT_LAST);
   assign player_dmg = 8'd15 + 8'd5 * {6'd0, menu_sel_q};
   assign enemy_dmg  = 8'd10 + 8'd10 * {5'd0, cur_battle};

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      result_d      = result_q;
      my_cur_d      = my_cur_q;
      enemy_id_d    = enemy_id_q;
      my_hp_d       = my_hp_q;
      enemy_hp_d    = enemy_hp_q;
      menu_sel_d    = menu_sel_q;
      prev_key_d    = keycode;
      prev_start_d  = start_battle;
      start_armed_d = start_armed_q | ~start_battle;

      case (state_q)
         S_IDLE: begin
            if (start_edge) state_d = S_INIT;
         end
         S_INIT: begin
            my_cur_d   = 2'd0;
            my_hp_d    = MAX_HP;
            menu_sel_d = 2'd0;
            enemy_hp_d = 8'd60 + 8'd10 * {5'd0, cur_battle};
            enemy_id_d = 3'd7 - cur_battle;
            result_d   = 1'b0;
            state_d    = S_PLAYER_TURN;
         end
         S_PLAYER_TURN: begin
            if (key_press) begin
               case (keycode)
                  KEY_W: menu_sel_d = menu_sel_q - 2'd1;
                  KEY_S: menu_sel_d = menu_sel_q + 2'd1;
                  KEY_ENTER: begin
                     enemy_hp_d = (enemy_hp_q > player_dmg) ? enemy_hp_q - player_dmg : 8'd0;
                     state_d    = S_PLAYER_ATTACK;
                  end
                  default: ;
               endcase
            end
         end
         S_PLAYER_ATTACK: begin
            if (wait_done) begin
               if (enemy_hp_q == 8'd0) begin
                  result_d = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  // enemy damage lands on the ENEMY_ATTACK entry edge
                  my_hp_d = (my_hp_q > enemy_dmg) ? my_hp_q - enemy_dmg : 8'd0;
                  state_d = S_ENEMY_ATTACK;
               end
            end
         end
         S_ENEMY_ATTACK: begin
            if (wait_done) begin
               if (my_hp_q != 8'd0) begin
                  state_d = S_PLAYER_TURN;
               end else if (my_cur_q == 2'd2) begin
                  result_d = 1'b0;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_FAINT;
               end
            end
         end
         S_FAINT: begin
            my_cur_d = my_cur_q + 2'd1;
            my_hp_d  = MAX_HP;
            state_d  = S_PLAYER_TURN;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q == S_PLAYER_ATTACK || state_q == S_ENEMY_ATTACK) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         result_q      <= 1'b0;
         my_cur_q      <= '0;
         enemy_id_q    <= '0;
         my_hp_q       <= '0;
         enemy_hp_q    <= '0;
         menu_sel_q    <= '0;
         prev_key_q    <= '0;
         prev_start_q  <= 1'b0;
         start_armed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         result_q      <= result_d;
         my_cur_q      <= my_cur_d;
         enemy_id_q    <= enemy_id_d;
         my_hp_q       <= my_hp_d;
         enemy_hp_q    <= enemy_hp_d;
         menu_sel_q    <= menu_sel_d;
         prev_key_q    <= prev_key_d;
         prev_start_q  <= prev_start_d;
         start_armed_q <= start_armed_d;
      end
   end

   assign end_battle   = (state_q == S_DONE);
   assign result       = result_q;
   assign my_cur       = my_cur_q;
   assign enemy_cur_id = enemy_id_q;
   assign my_hp        = my_hp_q;
   assign enemy_hp     = enemy_hp_q;
   assign menu_sel     = menu_sel_q;
   assign phase        = state_q;

endmodule

// File: doc/battle_engine.md
BATTLE_ENGINE -- requirements
Module: battle_engine

Interface
REQ-001 Parameter WAIT_CYCLES, default 25_000_000, sets the number of cycles each attack animation is held.
REQ-002 Parameter MY_MAX_HP, default 100, sets the full HP of each team member.
REQ-003 Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 start_battle  input  1  level from roam logic; a battle begins on its rising edge.
REQ-006 keycode  input  8  current keyboard code; 0x00 means no key; W=0x1A, S=0x16, ENTER=0x28.
REQ-007 my_team  input  9  three 3-bit creature ids; slot k is bits [3k+2:3k].
REQ-008 cur_battle  input  3  opponent index, 0..4.
REQ-009 end_battle  output  1  single-cycle pulse when a battle finishes.
REQ-010 result  output  1  1 = player won, 0 = player lost; valid from the end_battle cycle until the next battle starts.
REQ-011 my_cur  output  2  active team slot, 0..2.
REQ-012 enemy_cur_id  output  3  opponent creature id.
REQ-013 my_hp  output  8  active member HP.
REQ-014 enemy_hp  output  8  opponent HP.
REQ-015 menu_sel  output  2  highlighted move, 0..3.
REQ-016 phase  output  3  encoded state, for display logic.

Function
REQ-017 States and phase codes: IDLE=0, INIT=1, PLAYER_TURN=2, PLAYER_ATTACK=3, ENEMY_ATTACK=4, FAINT=5, DONE=6.
REQ-018 A key press is a cycle where keycode != 0 and keycode differs from the previous cycle's keycode; a held key acts once only.
REQ-019 IDLE -> INIT on a start_battle rising edge (0 in the previous cycle, 1 now); start_battle is ignored in every other state.
REQ-020 INIT behaviour (1 cycle):
- my_cur = 0, my_hp = MY_MAX_HP, menu_sel = 0.
- enemy_hp = 60 + 10*cur_battle.
- enemy_cur_id = 7 - cur_battle.
- Next state PLAYER_TURN.
REQ-021 PLAYER_TURN key handling:
- W press: menu_sel - 1, wrapping 0 -> 3.
- S press: menu_sel + 1, wrapping 3 -> 0.
- ENTER press: go to PLAYER_ATTACK; on the same edge, enemy_hp = enemy_hp - (15 + 5*menu_sel), saturating at 0.
- Any other key: ignored.
REQ-022 PLAYER_ATTACK timing:
- Holds exactly WAIT_CYCLES cycles.
- Then DONE with result=1 if enemy_hp == 0, otherwise ENEMY_ATTACK.
REQ-023 ENEMY_ATTACK timing:
- On entry edge, my_hp = my_hp - (10 + 10*cur_battle), saturating at 0.
- Holds WAIT_CYCLES cycles.
- Then, if my_hp > 0: PLAYER_TURN.
- If my_hp == 0 and my_cur == 2: DONE with result=0.
- Otherwise: FAINT.
REQ-024 FAINT (1 cycle): my_cur = my_cur + 1 and my_hp = MY_MAX_HP; next state PLAYER_TURN.
REQ-025 The wait counter is cleared on every state entry and is never shared between states.
REQ-026 All arithmetic is 8-bit unsigned; damage is computed at 8 bits before subtraction, and HP never wraps below 0.
REQ-027 DONE asserts end_battle for exactly one cycle, then goes to IDLE.
REQ-028 result, my_hp, enemy_hp and my_cur hold their final values in IDLE until the next INIT.
REQ-029 Keys are ignored outside PLAYER_TURN.

Reset
REQ-030 Reset, evaluated before all other logic:
- State = IDLE.
- end_battle=0, result=0, my_cur=0, enemy_cur_id=0, my_hp=0, enemy_hp=0, menu_sel=0.
- Wait counter and previous-key/previous-start registers cleared.
REQ-031 Reset asserted mid-battle abandons the battle with no end_battle pulse.
REQ-032 A start_battle level already high when Reset releases does not start a battle until it falls and rises again.

Verification (WAIT_CYCLES=4)
REQ-033 Quick win:
- Stimulus: cur_battle=0, start edge, S,S,S, ENTER, then ENTER after the enemy attack.
- Response: enemy_hp 60->30->0, my_hp 100->90, end_battle pulse, result=1, my_cur=0.
REQ-034 Loss:
- Stimulus: cur_battle=4, ENTER with menu_sel=0 six times.
- Response: my_cur steps 0->1->2, result=0, enemy_hp=10, exactly one end_battle pulse.
REQ-035 Menu wrap:
- W at menu_sel=0 -> 3.
- S at 3 -> 0.
- Holding W for 10 cycles changes menu_sel once.
REQ-036 Ignored inputs:
- ENTER during PLAYER_ATTACK: no HP change.
- start_battle toggled mid-battle: no re-INIT.
REQ-037 Reset mid-battle:
- Stimulus: assert Reset during ENEMY_ATTACK.
- Response: next cycle phase=0 and all outputs at reset values; no end_battle pulse.
REQ-038 Saturation: an enemy hit of 50 on my_hp=22 -> my_hp=0 followed by FAINT, not a wrapped value.
